// File: rtl/elbeth_load_store_unit.sv
// Memory-stage load/store unit: pipeline byte/half/word ops to dmem_* handshake with extend and faults.
// Latency k+1 cycles (ready in ACCESS cycle k); misaligned ops complete in 1; pipeline stalled while busy.
module elbeth_load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ls_valid,
    input  logic        ls_write,
    input  logic [2:0]  ls_op,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_stall,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        ls_except,
    output logic [3:0]  ls_except_src,
    output logic        dmem_en,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_out_data,
    output logic [3:0]  dmem_rw,
    input  logic [31:0] dmem_in_data,
    input  logic        dmem_ready,
    input  logic        dmem_except,
    input  logic [3:0]  dmem_except_src
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;
    logic          unsigned_q, unsigned_d;
    logic [1:0]    lo_q, lo_d;
    logic          dmem_en_q, dmem_en_d;
    logic [31:0]   dmem_addr_q, dmem_addr_d;
    logic [31:0]   dmem_out_q, dmem_out_d;
    logic [3:0]    dmem_rw_q, dmem_rw_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          except_q, except_d;
    logic [3:0]    src_q, src_d;

    // Size code: 00 byte, 01 half, 1x word (reserved funct3 values fall into word).
    logic [1:0]  req_size;
    logic        req_misaligned;
    logic [3:0]  req_rw;
    logic [31:0] req_out;

    always_comb begin
        req_size       = ls_op[1:0];
        req_misaligned = (req_size == 2'b01 && ls_addr[0]) ||
                         (req_size[1] && ls_addr[1:0] != 2'b00);
        case (req_size)
            2'b00: begin
                req_rw  = 4'b0001 << ls_addr[1:0];
                req_out = {4{ls_wdata[7:0]}};
            end
            2'b01: begin
                req_rw  = 4'b0011 << {ls_addr[1], 1'b0};
                req_out = {2{ls_wdata[15:0]}};
            end
            default: begin
                req_rw  = 4'b1111;
                req_out = ls_wdata;
            end
        endcase
    end

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    always_comb begin
        byte_sel = 8'(dmem_in_data >> {lo_q, 3'b000});
        half_sel = 16'(dmem_in_data >> {lo_q[1], 4'b0000});
        case (size_q)
            2'b00:   load_val = unsigned_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = unsigned_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = dmem_in_data;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        lo_d        = lo_q;
        dmem_en_d   = dmem_en_q;
        dmem_addr_d = dmem_addr_q;
        dmem_out_d  = dmem_out_q;
        dmem_rw_d   = dmem_rw_q;
        rdata_d     = rdata_q;
        except_d    = except_q;
        src_d       = src_q;
        case (state_q)
            ST_IDLE: begin
                if (ls_valid) begin
                    rdata_d    = 32'b0;
                    except_d   = 1'b0;
                    src_d      = 4'h0;
                    write_d    = ls_write;
                    size_d     = req_size;
                    unsigned_d = ls_op[2];
                    lo_d       = ls_addr[1:0];
                    if (req_misaligned) begin
                        except_d = 1'b1;
                        src_d    = ls_write ? 4'h6 : 4'h4;
                        state_d  = ST_RESP;
                    end else begin
                        dmem_en_d   = 1'b1;
                        dmem_addr_d = {ls_addr[31:2], 2'b00};
                        dmem_rw_d   = ls_write ? req_rw : 4'b0000;
                        dmem_out_d  = ls_write ? req_out : 32'b0;
                        cnt_d       = '0;
                        state_d     = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_except) begin
                    except_d = 1'b1;
                    src_d    = dmem_except_src;
                    state_d  = ST_RESP;
                end else if (dmem_ready) begin
                    if (!write_q) rdata_d = load_val;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    except_d = 1'b1;
                    src_d    = write_q ? 4'h7 : 4'h5;
                    state_d  = ST_RESP;
                end
                if (state_d == ST_RESP) begin
                    dmem_en_d = 1'b0;
                    dmem_rw_d = 4'b0000;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            lo_q        <= 2'b00;
            dmem_en_q   <= 1'b0;
            dmem_addr_q <= 32'b0;
            dmem_out_q  <= 32'b0;
            dmem_rw_q   <= 4'b0000;
            rdata_q     <= 32'b0;
            except_q    <= 1'b0;
            src_q       <= 4'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            lo_q        <= lo_d;
            dmem_en_q   <= dmem_en_d;
            dmem_addr_q <= dmem_addr_d;
            dmem_out_q  <= dmem_out_d;
            dmem_rw_q   <= dmem_rw_d;
            rdata_q     <= rdata_d;
            except_q    <= except_d;
            src_q       <= src_d;
        end
    end

    assign ls_stall      = (state_q == ST_IDLE && ls_valid) || (state_q == ST_ACCESS);
    assign ls_done       = (state_q == ST_RESP);
    assign ls_rdata      = rdata_q;
    assign ls_except     = except_q;
    assign ls_except_src = src_q;
    assign dmem_en       = dmem_en_q;
    assign dmem_addr     = dmem_addr_q;
    assign dmem_out_data = dmem_out_q;
    assign dmem_rw       = dmem_rw_q;

endmodule
